// File: rtl/code_transmitter.sv
// code_transmitter: sends a 4-digit BCD code to a lock and reports its response.
// Optional admin recovery sequence is enabled by defining CODE_TX_ADMIN_RECOVERY_EN.
module code_transmitter #(
    parameter logic [3:0] ADMIN_PASSWORD_0 = 4'd0,
    parameter logic [3:0] ADMIN_PASSWORD_1 = 4'd1,
    parameter logic [3:0] ADMIN_PASSWORD_2 = 4'd2,
    parameter logic [3:0] ADMIN_PASSWORD_3 = 4'd9,
    parameter int RESP_TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [15:0] code,
    input  logic        setReq,
    input  logic        unlockLight,
    input  logic        errorLight,
    input  logic        warningLight,
    output logic [3:0]  digit,
    output logic        setMode,
    output logic        busy,
    output logic        done,
    output logic [1:0]  result
);
    typedef enum logic [2:0] {
        IDLE,
`ifdef CODE_TX_ADMIN_RECOVERY_EN
        ADMIN,
`endif
        SEND,
        WAIT,
        DONE
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(RESP_TIMEOUT - 1);

    state_t state, nextState;
    logic [7:0] cnt, nextCnt;
    logic [15:0] codeReg;
    logic setReg;
    logic [1:0] nextResult;

    assign busy = state != IDLE;
    assign done = state == DONE;

    // State, counter, result and latched request registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt <= 8'd0;
            result <= 2'b00;
            codeReg <= 16'd0;
            setReg <= 1'b0;
        end else begin
            state <= nextState;
            cnt <= nextCnt;
            result <= nextResult;
            if (state == IDLE && start) begin
                codeReg <= code;
                setReg <= setReq;
            end
        end
    end

    // Next-state, counter, result and lock-facing outputs
    always_comb begin
        nextState = state;
        nextCnt = cnt;
        nextResult = result;
        digit = 4'hF;
        setMode = 1'b0;
        case (state)
            IDLE: begin
                nextCnt = 8'd0;
                if (start) begin
                    nextResult = 2'b00;
                    if (warningLight) begin
`ifdef CODE_TX_ADMIN_RECOVERY_EN
                        nextState = ADMIN;
`else
                        nextState = DONE;
                        nextResult = 2'b11;
`endif
                    end else begin
                        nextState = SEND;
                    end
                end
            end
`ifdef CODE_TX_ADMIN_RECOVERY_EN
            ADMIN: begin
                digit = cnt == 8'd0 ? ADMIN_PASSWORD_0 :
                        cnt == 8'd1 ? ADMIN_PASSWORD_1 :
                        cnt == 8'd2 ? ADMIN_PASSWORD_2 :
                        cnt == 8'd3 ? ADMIN_PASSWORD_3 : 4'hF;
                nextCnt = cnt == 8'd5 ? 8'd0 : cnt + 8'd1;
                nextState = cnt == 8'd5 ? SEND : ADMIN;
            end
`endif
            SEND: begin
                digit = codeReg[{cnt[1:0], 2'b00} +: 4];
                setMode = setReg;
                nextCnt = cnt == 8'd3 ? 8'd0 : cnt + 8'd1;
                nextState = cnt != 8'd3 ? SEND : setReg ? DONE : WAIT;
            end
            WAIT: begin
                nextCnt = cnt + 8'd1;
                if (errorLight) begin
                    nextState = DONE;
                    nextResult = 2'b10;
                end else if (unlockLight) begin
                    nextState = DONE;
                    nextResult = 2'b01;
                end else if (cnt == LAST_WAIT) begin
                    nextState = DONE;
                    nextResult = 2'b11;
                end
            end
            DONE: begin
                nextState = IDLE;
                nextCnt = 8'd0;
            end
            default: begin
                nextState = IDLE;
                nextCnt = 8'd0;
            end
        endcase
    end
endmodule

// File: tb/tb_code_transmitter.sv
// tb_code_transmitter: directed self-checking bench for code_transmitter (default build).
module tb_code_transmitter;
    localparam int TO = 6;

    logic CLK = 1'b0;
    logic RST, start, setReq, unlockLight, errorLight, warningLight;
    logic [15:0] code;
    logic [3:0] digit;
    logic setMode, busy, done;
    logic [1:0] result;
    int checks = 0;
    int errors = 0;

    code_transmitter #(.RESP_TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .start(start), .code(code), .setReq(setReq),
        .unlockLight(unlockLight), .errorLight(errorLight), .warningLight(warningLight),
        .digit(digit), .setMode(setMode), .busy(busy), .done(done), .result(result)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic out(input string tag, input logic [3:0] d, input logic sm, input logic b,
                       input logic dn, input logic [1:0] r);
        chk({tag, ".digit"}, 8'(digit), 8'(d));
        chk({tag, ".setMode"}, 8'(setMode), 8'(sm));
        chk({tag, ".busy"}, 8'(busy), 8'(b));
        chk({tag, ".done"}, 8'(done), 8'(dn));
        chk({tag, ".result"}, 8'(result), 8'(r));
    endtask

    initial begin
        RST = 1; start = 0; setReq = 0; unlockLight = 0; errorLight = 0; warningLight = 0;
        code = 16'h0;
        tick(); tick();
        out("reset", 4'hF, 0, 0, 0, 2'b00);
        RST = 0;
        tick();
        out("idle", 4'hF, 0, 0, 0, 2'b00);

        // validate: digits 1,2,3,4 then unlock on 2nd WAIT cycle
        code = 16'h4321; setReq = 0; start = 1;
        tick(); start = 0;
        out("val.d0", 4'h1, 0, 1, 0, 2'b00);
        tick(); out("val.d1", 4'h2, 0, 1, 0, 2'b00);
        tick(); out("val.d2", 4'h3, 0, 1, 0, 2'b00);
        tick(); out("val.d3", 4'h4, 0, 1, 0, 2'b00);
        tick(); out("val.w0", 4'hF, 0, 1, 0, 2'b00);
        tick(); out("val.w1", 4'hF, 0, 1, 0, 2'b00);
        unlockLight = 1;
        tick(); unlockLight = 0;
        out("val.done", 4'hF, 0, 1, 1, 2'b01);
        tick(); out("val.idle", 4'hF, 0, 0, 0, 2'b01);

        // set: setMode=1 with digits 0,7,8,9, DONE right after, result cleared at start
        code = 16'h9870; setReq = 1; start = 1;
        tick(); start = 0; setReq = 0;
        out("set.d0", 4'h0, 1, 1, 0, 2'b00);
        tick(); out("set.d1", 4'h7, 1, 1, 0, 2'b00);
        tick(); out("set.d2", 4'h8, 1, 1, 0, 2'b00);
        tick(); out("set.d3", 4'h9, 1, 1, 0, 2'b00);
        tick(); out("set.done", 4'hF, 0, 1, 1, 2'b00);
        tick(); out("set.idle", 4'hF, 0, 0, 0, 2'b00);

        // timeout: TO silent WAIT cycles then result 11
        code = 16'h1111; start = 1;
        tick(); start = 0;
        tick(); tick(); tick();
        tick(); out("to.w0", 4'hF, 0, 1, 0, 2'b00);
        for (int i = 1; i < TO; i++) begin
            tick();
            chk("to.wait.done", 8'(done), 8'd0);
        end
        tick(); out("to.done", 4'hF, 0, 1, 1, 2'b11);
        tick(); out("to.idle", 4'hF, 0, 0, 0, 2'b11);

        // tie: error and unlock together -> rejected
        code = 16'h0000; start = 1;
        tick(); start = 0;
        tick(); tick(); tick();
        tick();
        unlockLight = 1; errorLight = 1;
        tick(); unlockLight = 0; errorLight = 0;
        out("tie.done", 4'hF, 0, 1, 1, 2'b10);
        tick();

        // error alone on a later WAIT cycle
        code = 16'h2222; start = 1;
        tick(); start = 0;
        tick(); tick(); tick();
        tick(); tick(); tick();
        errorLight = 1;
        tick(); errorLight = 0;
        out("err.done", 4'hF, 0, 1, 1, 2'b10);
        tick();

        // lockout without admin recovery: DONE with 11 the cycle after start
        code = 16'h1234; warningLight = 1; start = 1;
        tick(); start = 0; warningLight = 0;
        out("lock.done", 4'hF, 0, 1, 1, 2'b11);
        tick(); out("lock.idle", 4'hF, 0, 0, 0, 2'b11);

        // digits above 9 go out unmodified
        code = 16'hBEAD; setReq = 1; start = 1;
        tick(); start = 0; setReq = 0;
        out("hex.d0", 4'hD, 1, 1, 0, 2'b00);
        tick(); chk("hex.d1", 8'(digit), 8'hA);
        tick(); chk("hex.d2", 8'(digit), 8'hE);
        tick(); chk("hex.d3", 8'(digit), 8'hB);
        tick(); tick();

        // start during busy ignored, then reset mid-SEND
        code = 16'h5678; setReq = 0; start = 1;
        tick();
        out("rst.d0", 4'h8, 0, 1, 0, 2'b00);
        code = 16'h0000; setReq = 1;
        tick(); start = 0;
        out("rst.d1", 4'h7, 0, 1, 0, 2'b00);
        RST = 1;
        tick();
        out("rst.after", 4'hF, 0, 0, 0, 2'b00);
        start = 1; code = 16'h4321; setReq = 0;
        tick();
        out("rst.prio", 4'hF, 0, 0, 0, 2'b00);
        RST = 0; start = 0;
        tick();
        out("rst.idle", 4'hF, 0, 0, 0, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
